// File: rtl/dft_pkg.sv
// Shared DFT constants and types used by the accumulator and its downstream
// peak search.
package dft_pkg;

  localparam int ACCUM_WIDTH_DEF = 48;
  localparam int NUM_BINS_DEF    = 16;
  localparam int BIN_IDX_W       = $clog2(NUM_BINS_DEF);

  typedef logic [BIN_IDX_W-1:0] bin_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } peak_state_t;

endpackage

// File: rtl/dft_mag_sq.sv
// Two-stage pipelined power |re|^2 + |im|^2 with LSB truncation.
// A valid bit and a bin tag travel alongside the data.
module dft_mag_sq #(
  parameter int ACCUM_WIDTH = 48,
  parameter int POW_WIDTH   = 64,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   valid_i,
  input  logic [TAG_WIDTH-1:0]   tag_i,
  input  logic [ACCUM_WIDTH-1:0] re_i,
  input  logic [ACCUM_WIDTH-1:0] im_i,
  output logic [POW_WIDTH-1:0]   pow_o,
  output logic [TAG_WIDTH-1:0]   tag_o,
  output logic                   valid_o
);

  localparam int SQ_W  = 2 * ACCUM_WIDTH;
  localparam int SHIFT = SQ_W + 1 - POW_WIDTH;

  // Full-width sign extension lets -2^(W-1) square to 2^(2W-2) exactly.
  logic signed [SQ_W-1:0] re_ext;
  logic signed [SQ_W-1:0] im_ext;
  logic [SQ_W-1:0]        re_sq_q;
  logic [SQ_W-1:0]        im_sq_q;
  logic                   valid1_q;
  logic [TAG_WIDTH-1:0]   tag1_q;

  assign re_ext = {{ACCUM_WIDTH{re_i[ACCUM_WIDTH-1]}}, re_i};
  assign im_ext = {{ACCUM_WIDTH{im_i[ACCUM_WIDTH-1]}}, im_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid1_q <= 1'b0;
      tag1_q   <= '0;
      re_sq_q  <= '0;
      im_sq_q  <= '0;
    end else begin
      valid1_q <= valid_i;
      if (valid_i) begin
        tag1_q  <= tag_i;
        re_sq_q <= re_ext * re_ext;
        im_sq_q <= im_ext * im_ext;
      end
    end
  end

  // The sum carries one extra bit, so dropping SHIFT LSBs never overflows.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      tag_o   <= '0;
      pow_o   <= '0;
    end else begin
      valid_o <= valid1_q;
      if (valid1_q) begin
        tag_o <= tag1_q;
        pow_o <= POW_WIDTH'(({1'b0, re_sq_q} + {1'b0, im_sq_q}) >> SHIFT);
      end
    end
  end

endmodule

// File: rtl/dft_peak_search.sv
// Snapshots a frame of complex DFT sums, streams per-bin power one bin per
// cycle, and reports the peak bin, its power and a threshold flag.
module dft_peak_search
  import dft_pkg::*;
#(
  parameter int ACCUM_WIDTH = ACCUM_WIDTH_DEF,
  parameter int NUM_BINS    = NUM_BINS_DEF,
  parameter int POW_WIDTH   = 64,
  localparam int BIN_W      = $clog2(NUM_BINS)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 valid_i,
  input  logic [NUM_BINS-1:0][ACCUM_WIDTH-1:0] A_real_i,
  input  logic [NUM_BINS-1:0][ACCUM_WIDTH-1:0] A_imag_i,
  input  logic [POW_WIDTH-1:0]                 thr_i,
  output logic [POW_WIDTH-1:0]                 pow_o,
  output logic [BIN_W-1:0]                     pow_bin_o,
  output logic                                 pow_valid_o,
  output logic [BIN_W-1:0]                     peak_bin_o,
  output logic [POW_WIDTH-1:0]                 peak_pow_o,
  output logic                                 above_thr_o,
  output logic                                 done_o,
  output logic                                 busy_o,
  output logic                                 overrun_o
);

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

  peak_state_t state_q, state_d;
  logic [BIN_W-1:0]                     idx_q;
  logic                                 drain_q;
  logic [NUM_BINS-1:0][ACCUM_WIDTH-1:0] re_snap_q;
  logic [NUM_BINS-1:0][ACCUM_WIDTH-1:0] im_snap_q;
  logic [POW_WIDTH-1:0]                 max_pow_q;
  logic [BIN_W-1:0]                     max_bin_q;

  logic                 take_new;
  logic                 last_pow;
  logic [POW_WIDTH-1:0] cand_pow;
  logic [BIN_W-1:0]     cand_bin;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i) state_d = SCAN;
      SCAN:    if (idx_q == LAST_BIN) state_d = DRAIN;
      DRAIN:   if (drain_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= (state_q == SCAN) ? idx_q + 1'b1 : '0;
      drain_q <= (state_q == DRAIN) ? ~drain_q : 1'b0;
    end
  end

  // The snapshot only loads from IDLE, so a dropped valid_i never disturbs a scan.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      re_snap_q <= '0;
      im_snap_q <= '0;
    end else if (state_q == IDLE && valid_i) begin
      re_snap_q <= A_real_i;
      im_snap_q <= A_imag_i;
    end
  end

  dft_mag_sq #(
    .ACCUM_WIDTH (ACCUM_WIDTH),
    .POW_WIDTH   (POW_WIDTH),
    .TAG_WIDTH   (BIN_W)
  ) u_mag_sq (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (state_q == SCAN),
    .tag_i   (idx_q),
    .re_i    (re_snap_q[idx_q]),
    .im_i    (im_snap_q[idx_q]),
    .pow_o   (pow_o),
    .tag_o   (pow_bin_o),
    .valid_o (pow_valid_o)
  );

  // Bin 0 seeds the running max; strict compare keeps the lowest index on ties.
  always_comb begin
    take_new = pow_valid_o && (pow_bin_o == '0 || pow_o > max_pow_q);
    last_pow = pow_valid_o && (pow_bin_o == LAST_BIN);
    cand_pow = take_new ? pow_o : max_pow_q;
    cand_bin = take_new ? pow_bin_o : max_bin_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      max_pow_q   <= '0;
      max_bin_q   <= '0;
      peak_pow_o  <= '0;
      peak_bin_o  <= '0;
      above_thr_o <= 1'b0;
      done_o      <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      max_pow_q <= cand_pow;
      max_bin_q <= cand_bin;
      done_o    <= last_pow;
      overrun_o <= valid_i && (state_q != IDLE);
      if (last_pow) begin
        peak_pow_o  <= cand_pow;
        peak_bin_o  <= cand_bin;
        above_thr_o <= (cand_pow >= thr_i);
      end
    end
  end

  assign busy_o = (state_q != IDLE);

endmodule
